final_project_soc_from_hw_port: RTL



---
 rtl/final_project_soc_from_hw_port.sv | 118 +++++++++++
 1 files changed

// File: rtl/final_project_soc_from_hw_port.sv
// Hardware-to-CPU input port: a FIFO filled by fabric logic over valid/ready
// and drained by the Nios CPU through a 4-word Avalon-MM register map.
module final_project_soc_from_hw_port #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        irq
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, wr_addr;
    logic [AW:0]   count, count_n;
    logic [1:0]    mask, mask_n;
    logic          underflow, underflow_n;
    logic [31:0]   readdata_n, status;
    logic          rd, wr, empty, full, push, pop, flush, empty_rd;
    logic          unused;

    assign unused = ^{writedata[31:19], writedata[17:2]};

    assign rd       = chipselect & ~read_n;
    assign wr       = chipselect & ~write_n;
    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    assign pop      = rd & (address == 2'd0) & ~empty;
    assign empty_rd = rd & (address == 2'd0) & empty;
    assign flush    = wr & (address == 2'd3) & writedata[0];
    // A push during a flush lands in slot 0 of the freshly emptied FIFO
    assign wr_addr  = flush ? '0 : wr_ptr;

    always_comb begin
        status        = '0;
        status[AW:0]  = count;
        status[16]    = empty;
        status[17]    = full;
        status[18]    = underflow;
    end

    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        count_n  = count;
        if (flush) begin
            rd_ptr_n = '0;
            wr_ptr_n = push ? AW'(1) : '0;
            count_n  = push ? (AW+1)'(1) : '0;
        end else begin
            if (push) wr_ptr_n = wr_ptr + 1'b1;
            if (pop)  rd_ptr_n = rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_n = count + 1'b1;
                2'b01:   count_n = count - 1'b1;
                default: count_n = count;
            endcase
        end
    end

    always_comb begin
        mask_n      = mask;
        underflow_n = underflow;
        if (wr && address == 2'd2) mask_n = writedata[1:0];
        if (wr && address == 2'd1 && writedata[18]) underflow_n = 1'b0;
        if (empty_rd) underflow_n = 1'b1;
    end

    always_comb begin
        readdata_n = readdata;
        if (rd) begin
            case (address)
                2'd0:    readdata_n = empty ? 32'd0 : mem[rd_ptr];
                2'd1:    readdata_n = status;
                2'd2:    readdata_n = {30'd0, mask};
                default: readdata_n = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_addr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            mask      <= '0;
            underflow <= 1'b0;
            readdata  <= '0;
            irq       <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            mask      <= mask_n;
            underflow <= underflow_n;
            readdata  <= readdata_n;
            irq       <= (mask_n[0] & (count_n != '0))
                       | (mask_n[1] & (count_n == FULL_CNT));
        end
    end

endmodule
